// File: rtl/pz_sched_pkg.sv
// Shared types for the pole/zero phase scheduler: FSM states, response tag
// layout and the field positions inside one packed pole/zero word.
package pz_sched_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        DRAIN  = 2'd2,
        OUTPUT = 2'd3
    } pz_state_e;

    typedef struct packed {
        logic valid;
        logic enable;
        logic is_pole;
    } pz_tag_t;

    localparam int PZ_WORD_W  = 32;
    localparam int PZ_FIELD_W = 16;
    localparam int PZ_RE_MSB  = 31;
    localparam int PZ_RE_LSB  = 16;
    localparam int PZ_IM_MSB  = 15;
    localparam int PZ_IM_LSB  = 0;

    function automatic pz_tag_t make_tag(input logic valid, input logic enable,
                                         input logic is_pole);
        pz_tag_t t;
        t.valid   = valid;
        t.enable  = enable;
        t.is_pole = is_pole;
        return t;
    endfunction

endpackage

// File: rtl/pz_tag_delay.sv
// Fixed-depth shift register that walks each request's tag alongside the
// shared atan pipeline so the tag emerges together with its angle.
module pz_tag_delay
    import pz_sched_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic    clk,
    input  logic    resetn,
    input  pz_tag_t tag_i,
    output pz_tag_t tag_o
);

    pz_tag_t pipe_q [DEPTH];

    // NOTE: every register here uses non-blocking assignment so all stages
    // sample the previous stage's old value on the same edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q[0] <= tag_i;
            for (int i = 1; i < DEPTH; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign tag_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/pz_phase_scheduler.sv
// Time-multiplexed pole/zero phase accumulator driving one shared atan unit.
// Optional PZ_SCHED_STALL_CNT_EN adds a saturating output-backpressure counter.
module pz_phase_scheduler
    import pz_sched_pkg::*;
#(
    parameter int NUM_PZ   = 8,
    parameter int COORD_W  = 16,
    parameter int PHASE_W  = 16,
    parameter int ATAN_LAT = 2
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic [PZ_WORD_W*NUM_PZ-1:0] pz_flat,
    input  logic [NUM_PZ-1:0]           pz_enable,
    input  logic [NUM_PZ-1:0]           pz_is_pole,
    input  logic                        pix_valid,
    output logic                        pix_ready,
    input  logic [COORD_W-1:0]          pix_re,
    input  logic [COORD_W-1:0]          pix_im,
    input  logic                        pix_first,
    input  logic                        pix_lastx,
    output logic                        atan_valid,
    output logic [COORD_W-1:0]          atan_x,
    output logic [COORD_W-1:0]          atan_y,
    input  logic [PHASE_W-1:0]          atan_angle,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [PHASE_W-1:0]          out_phase,
    output logic                        out_first,
    output logic                        out_lastx
`ifdef PZ_SCHED_STALL_CNT_EN
    ,
    output logic [31:0]                 stall_cnt
`endif
);

    localparam int IDX_W = $clog2(NUM_PZ);
    localparam int DRN_W = $clog2(ATAN_LAT + 1);

    pz_state_e                   state_q, state_d;
    logic [IDX_W-1:0]            idx_q, idx_d;
    logic [DRN_W-1:0]            drain_q, drain_d;
    logic [PHASE_W-1:0]          acc_q, acc_d;

    logic [PZ_WORD_W*NUM_PZ-1:0] pz_q;
    logic [NUM_PZ-1:0]           en_q;
    logic [NUM_PZ-1:0]           pole_q;
    logic [COORD_W-1:0]          pix_re_q;
    logic [COORD_W-1:0]          pix_im_q;
    logic                        first_q;
    logic                        lastx_q;

    logic                        pix_fire;
    logic                        issuing;
    logic [PZ_WORD_W-1:0]        cur_word;
    logic signed [COORD_W-1:0]   w_re_ext;
    logic signed [COORD_W-1:0]   w_im_ext;
    pz_tag_t                     tag_in;
    pz_tag_t                     tag_out;

    assign pix_ready = resetn && (state_q == IDLE);
    assign pix_fire  = pix_valid && pix_ready;
    assign issuing   = (state_q == ISSUE);

    assign cur_word = pz_q[idx_q*PZ_WORD_W +: PZ_WORD_W];
    assign w_re_ext = COORD_W'($signed(cur_word[PZ_RE_MSB:PZ_RE_LSB]));
    assign w_im_ext = COORD_W'($signed(cur_word[PZ_IM_MSB:PZ_IM_LSB]));

    assign atan_valid = issuing;
    assign atan_x     = issuing ? pix_re_q - w_re_ext : '0;
    assign atan_y     = issuing ? pix_im_q - w_im_ext : '0;

    assign tag_in = make_tag(issuing, en_q[idx_q], pole_q[idx_q]);

    pz_tag_delay #(
        .DEPTH (ATAN_LAT)
    ) u_tag_delay (
        .clk    (clk),
        .resetn (resetn),
        .tag_i  (tag_in),
        .tag_o  (tag_out)
    );

    // NOTE: every next-state variable is defaulted to its current value first,
    // so no path through the case statement leaves one unassigned (no latch).
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        drain_d = drain_q;
        acc_d   = acc_q;

        case (state_q)
            IDLE: begin
                if (pix_fire) begin
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (idx_q == IDX_W'(NUM_PZ - 1)) begin
                    idx_d   = '0;
                    drain_d = '0;
                    state_d = DRAIN;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DRAIN: begin
                if (drain_q == DRN_W'(ATAN_LAT - 1)) begin
                    state_d = OUTPUT;
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end
            OUTPUT: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Responses only ever land during ISSUE/DRAIN of the pixel that made them.
        if (tag_out.valid && tag_out.enable) begin
            acc_d = tag_out.is_pole ? acc_d - atan_angle : acc_d + atan_angle;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            idx_q   <= '0;
            drain_q <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            drain_q <= drain_d;
            acc_q   <= acc_d;
        end
    end

    // NOTE: the captured pixel/config registers carry no reset: they are
    // always loaded on the handshake before ISSUE reads them, and every
    // output that depends on them is gated by the reset-cleared state.
    always_ff @(posedge clk) begin
        if (pix_fire) begin
            pz_q     <= pz_flat;
            en_q     <= pz_enable;
            pole_q   <= pz_is_pole;
            pix_re_q <= pix_re;
            pix_im_q <= pix_im;
            first_q  <= pix_first;
            lastx_q  <= pix_lastx;
        end
    end

    assign out_valid = (state_q == OUTPUT);
    assign out_phase = out_valid ? acc_q : '0;
    assign out_first = out_valid && first_q;
    assign out_lastx = out_valid && lastx_q;

`ifdef PZ_SCHED_STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stall_cnt_q <= '0;
        end else if (out_valid && !out_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pz_phase_scheduler.sv
// Directed bench for pz_phase_scheduler with a mock atan unit that returns
// atan_x zero-extended ATAN_LAT cycles after each request.
`timescale 1ns/1ps
module tb_pz_phase_scheduler;

    localparam int NUM_PZ   = 8;
    localparam int COORD_W  = 16;
    localparam int PHASE_W  = 16;
    localparam int ATAN_LAT = 2;
    localparam int LATENCY  = NUM_PZ + ATAN_LAT + 1;
    localparam int PERIOD   = NUM_PZ + ATAN_LAT + 2;

    logic                     clk = 1'b0;
    logic                     resetn = 1'b0;
    logic [32*NUM_PZ-1:0]     pz_flat = '0;
    logic [NUM_PZ-1:0]        pz_enable = '0;
    logic [NUM_PZ-1:0]        pz_is_pole = '0;
    logic                     pix_valid = 1'b0;
    logic                     pix_ready;
    logic [COORD_W-1:0]       pix_re = '0;
    logic [COORD_W-1:0]       pix_im = '0;
    logic                     pix_first = 1'b0;
    logic                     pix_lastx = 1'b0;
    logic                     atan_valid;
    logic [COORD_W-1:0]       atan_x;
    logic [COORD_W-1:0]       atan_y;
    logic [PHASE_W-1:0]       atan_angle;
    logic                     out_valid;
    logic                     out_ready = 1'b1;
    logic [PHASE_W-1:0]       out_phase;
    logic                     out_first;
    logic                     out_lastx;
`ifdef PZ_SCHED_STALL_CNT_EN
    logic [31:0]              stall_cnt;
`endif

    int n_pass   = 0;
    int n_checks = 0;
    int cyc      = 0;
    int req_cnt  = 0;
    int req_base = 0;
    int hs_cyc   = 0;
    int prev_hs  = 0;

    logic [PHASE_W-1:0] mock_q [ATAN_LAT];

    pz_phase_scheduler #(
        .NUM_PZ   (NUM_PZ),
        .COORD_W  (COORD_W),
        .PHASE_W  (PHASE_W),
        .ATAN_LAT (ATAN_LAT)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .pz_flat    (pz_flat),
        .pz_enable  (pz_enable),
        .pz_is_pole (pz_is_pole),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .pix_re     (pix_re),
        .pix_im     (pix_im),
        .pix_first  (pix_first),
        .pix_lastx  (pix_lastx),
        .atan_valid (atan_valid),
        .atan_x     (atan_x),
        .atan_y     (atan_y),
        .atan_angle (atan_angle),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_phase  (out_phase),
        .out_first  (out_first),
        .out_lastx  (out_lastx)
`ifdef PZ_SCHED_STALL_CNT_EN
        ,
        .stall_cnt  (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (atan_valid === 1'b1) req_cnt <= req_cnt + 1;
    end

    // Mock atan: angle = atan_x, delayed ATAN_LAT cycles.
    always @(posedge clk) begin
        mock_q[0] <= PHASE_W'(atan_x);
        for (int i = 1; i < ATAN_LAT; i++) mock_q[i] <= mock_q[i-1];
    end
    assign atan_angle = mock_q[ATAN_LAT-1];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_entry(input int i, input logic [15:0] re, input logic [15:0] im,
                             input logic en, input logic pole);
        pz_flat[i*32 +: 32] = {re, im};
        pz_enable[i]        = en;
        pz_is_pole[i]       = pole;
    endtask

    // Disabled entries get distinct non-zero contents so a gating bug shows up.
    task automatic clear_cfg();
        for (int i = 0; i < NUM_PZ; i++) begin
            set_entry(i, 16'(i*1000 + 7), 16'(i*3 + 1), 1'b0, i[0]);
        end
    endtask

    task automatic send_pixel(input logic [15:0] re, input logic [15:0] im,
                              input logic first, input logic lastx);
        bit accepted;
        accepted  = 1'b0;
        req_base  = req_cnt;
        pix_re    = re;
        pix_im    = im;
        pix_first = first;
        pix_lastx = lastx;
        pix_valid = 1'b1;
        for (int n = 0; n < 40 && !accepted; n++) begin
            @(negedge clk);
            accepted = (pix_ready === 1'b1);
            @(posedge clk);
            #1;
        end
        pix_valid = 1'b0;
        prev_hs   = hs_cyc;
        hs_cyc    = cyc;
        check("pix_accept", 32'(accepted), 32'd1);
    endtask

    task automatic wait_output(output int lat);
        while (out_valid !== 1'b1 && (cyc - hs_cyc) < 60) begin
            @(posedge clk);
            #1;
        end
        lat = cyc - hs_cyc + 1;
    endtask

    task automatic finish_pixel(input string name, input logic [15:0] exp_phase,
                                input logic ef, input logic el);
        int lat;
        wait_output(lat);
        check({name, "_latency"}, 32'(lat), 32'(LATENCY));
        check({name, "_phase"}, 32'(out_phase), 32'(exp_phase));
        check({name, "_flags"}, {30'd0, out_first, out_lastx}, {30'd0, ef, el});
        check({name, "_requests"}, 32'(req_cnt - req_base), 32'(NUM_PZ));
        @(posedge clk);
        #1;
        check({name, "_release"}, {30'd0, out_valid, pix_ready}, 32'd1);
    endtask

    initial begin
        int lat;
        int bad;
        clear_cfg();

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_pix_ready", 32'(pix_ready), 32'd0);
        check("rst_atan_valid", 32'(atan_valid), 32'd0);
        check("rst_atan_x", 32'(atan_x), 32'd0);
        check("rst_atan_y", 32'(atan_y), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_phase", 32'(out_phase), 32'd0);
        check("rst_out_flags", {30'd0, out_first, out_lastx}, 32'd0);
`ifdef PZ_SCHED_STALL_CNT_EN
        check("rst_stall_cnt", stall_cnt, 32'd0);
`endif
        resetn = 1'b1;
        #1;
        check("ready_after_reset", 32'(pix_ready), 32'd1);

        // 1: all entries disabled
        send_pixel(16'd100, 16'd5, 1'b1, 1'b0);
        finish_pixel("all_off", 16'd0, 1'b1, 1'b0);

        // 2: single zero at (10,0), back-to-back with the previous pixel
        clear_cfg();
        set_entry(0, 16'd10, 16'd0, 1'b1, 1'b0);
        send_pixel(16'd100, 16'd5, 1'b0, 1'b0);
        check("throughput", 32'(hs_cyc - prev_hs), 32'(PERIOD));
        check("one_zero_req0_valid", 32'(atan_valid), 32'd1);
        check("one_zero_req0_x", 32'(atan_x), 32'd90);
        check("one_zero_req0_y", 32'(atan_y), 32'd5);
        finish_pixel("one_zero", 16'd90, 1'b0, 1'b0);

        // 3: zero (10,0) + pole (30,0); config scrambled after capture
        clear_cfg();
        set_entry(0, 16'd10, 16'd0, 1'b1, 1'b0);
        set_entry(1, 16'd30, 16'd0, 1'b1, 1'b1);
        send_pixel(16'd100, 16'd5, 1'b0, 1'b1);
        pz_flat   = {NUM_PZ{32'h1234_5678}};
        pz_enable = '1;
        pz_is_pole = '0;
        finish_pixel("zero_pole", 16'd20, 1'b0, 1'b1);

        // 4: single pole at (10,0), pixel at origin -> 0 - 0xFFF6 = 0x000A
        clear_cfg();
        set_entry(0, 16'd10, 16'd0, 1'b1, 1'b1);
        send_pixel(16'd0, 16'd0, 1'b1, 1'b1);
        check("neg_req0_x", 32'(atan_x), 32'h0000_FFF6);
        finish_pixel("neg_pole", 16'h000A, 1'b1, 1'b1);

        // 5: eight zeros at origin, pixel 0x3000 -> 8*0x3000 mod 2^16 = 0x8000
        for (int i = 0; i < NUM_PZ; i++) set_entry(i, 16'd0, 16'd0, 1'b1, 1'b0);
        send_pixel(16'h3000, 16'd0, 1'b0, 1'b0);
        finish_pixel("all_zeros_wrap", 16'h8000, 1'b0, 1'b0);

        // 6: subtraction overflow on entry 3: 0x7FFF - (-1) wraps to 0x8000
        clear_cfg();
        set_entry(3, 16'hFFFF, 16'd2, 1'b1, 1'b0);
        send_pixel(16'h7FFF, 16'd1, 1'b0, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        check("ovf_req3_x", 32'(atan_x), 32'h0000_8000);
        check("ovf_req3_y", 32'(atan_y), 32'h0000_FFFF);
        finish_pixel("sub_overflow", 16'h8000, 1'b0, 1'b1);

        // 7: 20-cycle backpressure stall
        clear_cfg();
        set_entry(0, 16'd10, 16'd0, 1'b1, 1'b0);
        set_entry(1, 16'd30, 16'd0, 1'b1, 1'b1);
        out_ready = 1'b0;
        send_pixel(16'd100, 16'd5, 1'b1, 1'b1);
        wait_output(lat);
        check("stall_latency", 32'(lat), 32'(LATENCY));
        check("stall_phase", 32'(out_phase), 32'd20);
        bad = 0;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk);
            #1;
            if (n == 0) begin
                pix_valid = 1'b1;
                pix_re    = 16'd999;
            end
            if (out_valid !== 1'b1 || out_phase !== 16'd20 || out_first !== 1'b1 ||
                out_lastx !== 1'b1 || pix_ready !== 1'b0 || atan_valid !== 1'b0) bad++;
        end
        check("stall_stable_cycles_bad", 32'(bad), 32'd0);
`ifdef PZ_SCHED_STALL_CNT_EN
        check("stall_cnt", stall_cnt, 32'd20);
`endif
        pix_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("stall_release", {30'd0, out_valid, pix_ready}, 32'd1);

        // 8: short reset pulse during ISSUE at idx=3, then a clean pixel
        for (int i = 0; i < NUM_PZ; i++) set_entry(i, 16'd0, 16'd0, 1'b1, 1'b0);
        send_pixel(16'd500, 16'd7, 1'b1, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        check("abort_req3_x", 32'(atan_x), 32'd500);
        resetn = 1'b0;
        #1;
        check("abort_atan_valid", 32'(atan_valid), 32'd0);
        check("abort_atan_x", 32'(atan_x), 32'd0);
        check("abort_atan_y", 32'(atan_y), 32'd0);
        check("abort_pix_ready", 32'(pix_ready), 32'd0);
        check("abort_out", {15'd0, out_valid, out_phase}, 32'd0);
        check("abort_flags", {30'd0, out_first, out_lastx}, 32'd0);
`ifdef PZ_SCHED_STALL_CNT_EN
        check("abort_stall_cnt", stall_cnt, 32'd0);
`endif
        resetn = 1'b1;
        #1;
        check("abort_ready_again", 32'(pix_ready), 32'd1);
        clear_cfg();
        set_entry(0, 16'd10, 16'd0, 1'b1, 1'b0);
        set_entry(1, 16'd30, 16'd0, 1'b1, 1'b1);
        send_pixel(16'd100, 16'd5, 1'b0, 1'b0);
        finish_pixel("post_reset", 16'd20, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pz_phase_scheduler.md
# pz_phase_scheduler

Time-multiplexed controller that computes the accumulated pole/zero phase for each pixel coordinate using one shared atan unit, replacing NUM_PZ parallel subtract/atan lanes. It sits between coordinate_gen and phase_to_rgb in the pixel generator stream clock domain. It accepts one coordinate per handshake and issues one subtract/atan request per pole/zero entry. It sums the returned angles, with zeros added and poles subtracted, and presents the summed phase with the stream flags on a valid/ready output.

## Interface
- NUM_PZ, 8, number of pole/zero entries; must be ≥2.
- COORD_W, 16, signed coordinate width.
- PHASE_W, 16, angle width; unsigned modulo-2^PHASE_W turns.
- ATAN_LAT, 2, fixed latency of the shared atan unit in cycles; must be ≥1.

- clk  in  1  stream clock (out_stream_aclk domain).
- resetn  in  1  reset; asynchronous assert, active-low.
- pz_flat  in  32*NUM_PZ  entry i is at [i*32 +: 32]; re = [31:16], im = [15:0].
- pz_enable  in  NUM_PZ  a cleared bit excludes that entry from the sum.
- pz_is_pole  in  NUM_PZ  1 = pole (subtract), 0 = zero (add).
- pix_valid  in  1  coordinate valid.
- pix_ready  out  1  coordinate accepted.
- pix_re, pix_im  in  COORD_W  coordinate.
- pix_first, pix_lastx  in  1  start-of-frame and end-of-line flags.
- atan_valid  out  1  request to the shared atan unit.
- atan_x, atan_y  out  COORD_W  request operands.
- atan_angle  in  PHASE_W  result; valid exactly ATAN_LAT cycles after the request.
- out_valid  out  1  phase valid.
- out_ready  in  1  downstream accept.
- out_phase  out  PHASE_W  accumulated phase.
- out_first, out_lastx  out  1  flags captured with the pixel.

## Operation
- States: IDLE, ISSUE, DRAIN, OUTPUT.
- IDLE: pix_ready=1.
  - On pix_valid&&pix_ready, capture pix_re, pix_im, pix_first, pix_lastx, pz_flat, pz_enable and pz_is_pole.
  - Clear the accumulator, set idx=0, go to ISSUE.
- ISSUE:
  - atan_valid=1, atan_x = pix_re − w_re[idx], atan_y = pix_im − w_im[idx].
  - Subtraction is two's complement, truncated to COORD_W, wrapping on overflow.
  - Increment idx each cycle. At idx = NUM_PZ−1, idx wraps to 0 and the state moves to DRAIN.
- DRAIN: hold for ATAN_LAT cycles with atan_valid=0, then go to OUTPUT.
- Response tracking:
  - A tag shift register of depth ATAN_LAT carries {valid, enable, is_pole}.
  - When a tag emerges valid with enable=1, acc = acc ± atan_angle, modulo 2^PHASE_W. Poles subtract, zeros add.
  - When enable=0, the response is discarded.
- OUTPUT:
  - out_valid=1, holding out_phase=acc and the captured flags stable.
  - On out_ready, go to IDLE.
- pix_ready is asserted only in IDLE. There is no overlap between pixels.
- Config changes after capture do not affect the pixel in flight.
- Reset mid-operation: state, idx, accumulator and tag register all clear. In-flight atan responses are ignored.

## Timing
- Reset values: pix_ready=0 while resetn low, then 1 in the first IDLE cycle. atan_valid=0, atan_x=atan_y=0, out_valid=0, out_phase=0, out_first=out_lastx=0.
- Latency: pixel handshake at edge 0; requests on cycles 1..NUM_PZ; last accumulate at edge NUM_PZ+ATAN_LAT; out_valid at cycle NUM_PZ+ATAN_LAT+1.
  - Defaults: out_valid at cycle 11.
- Throughput: one pixel per NUM_PZ+ATAN_LAT+2 cycles when out_ready is held high (12 with defaults).
- A backpressure stall holds OUTPUT indefinitely. No request is issued during a stall.
- pix_valid asserted outside IDLE is not accepted. The upstream block must hold its data until pix_ready.

## Configuration
- PZ_SCHED_STALL_CNT_EN defined:
  - Adds an output stall_cnt[31:0].
  - It increments each cycle out_valid&&!out_ready and saturates at 0xFFFFFFFF.
  - It clears on reset only.
- Undefined: the port and counter are absent. Behaviour is otherwise identical.

## Structure
- Package pz_sched_pkg holds:
  - the state enum {IDLE, ISSUE, DRAIN, OUTPUT};
  - the tag struct {valid, enable, is_pole};
  - localparams for the field slices of a pz_flat word.
- Sub-module pz_tag_delay holds the ATAN_LAT-deep tag shift register with async reset.
- The shared atan unit is instantiated outside this block.

## Test plan
The bench uses a mock atan unit that returns atan_x zero-extended to PHASE_W, ATAN_LAT cycles after each request.

- All entries disabled, pixel (100,5) -> out_phase=0, out_valid at cycle 11.
- Only entry 0 enabled, as a zero at (10,0); pixel (100,5) -> out_phase=90.
- Entry 0 a zero at (10,0) and entry 1 a pole at (30,0); pixel (100,5) -> 90−70 = 20.
- Single pole at (10,0); pixel (0,0) -> atan_x = −10 (0xFFF6 as a 16-bit value). acc = 0 − 0xFFF6 wraps to 0x000A.
- Hold out_ready=0 for 20 cycles -> out_phase and flags stable, pix_ready=0, atan_valid=0. With PZ_SCHED_STALL_CNT_EN, stall_cnt=20.
- Deassert resetn during ISSUE at idx=3 -> all outputs return to reset values at once. After release, the next pixel produces the correct phase with no residue from the aborted pixel.
